// File: rtl/frame_header_parser_pkg.sv
// Shared definitions for the frame header parser and the payload/CRC stage.
// Holds the FSM state encodings, framing byte values, the broadcast byte, the
// default address width and a small constant helper used to size counters.
package frame_header_parser_pkg;

  // Parser states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_SFD      = 3'd2;
  localparam logic [2:0] ST_DEST     = 3'd3;
  localparam logic [2:0] ST_SRC      = 3'd4;
  localparam logic [2:0] ST_PAYLOAD  = 3'd5;

  // Framing constants
  localparam logic [7:0] PREAMBLE_BYTE_DEF = 8'h55;
  localparam logic [7:0] SFD_BYTE_DEF      = 8'hD5;
  localparam logic [7:0] BCAST_BYTE        = 8'hFF;
  localparam int         ADDR_W            = 48;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/frame_header_parser_field_byte_counter.sv
// Byte counter shared by every frame field.
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   clear          : restart the count; clear together with inc loads 1
//   inc            : count one byte
//   term           : index of the last byte of the current field
//   count          : bytes counted so far in the current field
//   last           : the byte being sampled now is the last of the field
module field_byte_counter #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      // The first preamble byte is counted on the same edge that opens the field.
      count <= {{(W-1){1'b0}}, inc};
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == term);

endmodule

// File: rtl/frame_header_parser.sv
// Byte-serial frame header parser: hunts for the preamble, checks the SFD,
// filters on destination address, captures the source address and then holds
// payload_enable high for exactly the payload+CRC byte window.
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   byte_in        : frame byte, sampled when byte_valid=1
//   byte_valid     : byte_in is valid this cycle
//   payload_enable : high during the cycles that carry payload/CRC bytes
//   dst_broadcast  : accepted frame was broadcast; held until next SFD
//   src_addr       : captured source address; held until next SFD
//   frame_done     : pulse after the last payload byte
//   frame_drop     : pulse when the destination is neither local nor broadcast
//   header_error   : pulse on bad preamble/SFD or a byte_valid gap mid-frame
module frame_header_parser
  import frame_header_parser_pkg::*;
#(
  parameter int                      PREAMBLE_LEN  = 7,
  parameter logic [7:0]              PREAMBLE_BYTE = PREAMBLE_BYTE_DEF,
  parameter logic [7:0]              SFD_BYTE      = SFD_BYTE_DEF,
  parameter int                      ADDR_BYTES    = ADDR_W / 8,
  parameter logic [8*ADDR_BYTES-1:0] LOCAL_ADDR    = 48'h0A0B0C0D0E0F,
  parameter int                      PAYLOAD_BYTES = 50
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    payload_enable,
  output logic                    dst_broadcast,
  output logic [8*ADDR_BYTES-1:0] src_addr,
  output logic                    frame_done,
  output logic                    frame_drop,
  output logic                    header_error
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int CW = $clog2(max3(PREAMBLE_LEN, ADDR_BYTES, PAYLOAD_BYTES) + 1);

  logic [2:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_term;
  logic          cnt_last, cnt_clear, cnt_inc;
  logic          local_match, bcast_match, local_match_d, bcast_match_d;
  logic          local_now, bcast_now;
  logic          pe_d, bcast_d, done_d, drop_d, err_d;
  logic [AW-1:0] src_d, local_sh;

  field_byte_counter #(.W(CW)) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .term    (cnt_term),
    .count   (cnt),
    .last    (cnt_last)
  );

  always_comb begin
    cnt_term = '0;
    case (state)
      ST_PREAMBLE:    cnt_term = CW'(PREAMBLE_LEN - 1);
      ST_DEST, ST_SRC: cnt_term = CW'(ADDR_BYTES - 1);
      ST_PAYLOAD:     cnt_term = CW'(PAYLOAD_BYTES - 1);
      default:        cnt_term = '0;
    endcase
  end

  // Destination byte under test, MSB byte first.
  assign local_sh  = LOCAL_ADDR << (8 * cnt);
  assign local_now = local_match & (byte_in == local_sh[AW-1 -: 8]);
  assign bcast_now = bcast_match & (byte_in == BCAST_BYTE);

  always_comb begin
    state_d       = state;
    pe_d          = payload_enable;
    bcast_d       = dst_broadcast;
    src_d         = src_addr;
    local_match_d = local_match;
    bcast_match_d = bcast_match;
    done_d        = 1'b0;
    drop_d        = 1'b0;
    err_d         = 1'b0;
    cnt_clear     = 1'b0;
    cnt_inc       = 1'b0;

    if (state != ST_IDLE && !byte_valid) begin
      // Bytes must be contiguous once a frame has started.
      state_d   = ST_IDLE;
      pe_d      = 1'b0;
      err_d     = 1'b1;
      cnt_clear = 1'b1;
    end else if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (byte_in == PREAMBLE_BYTE) begin
            state_d   = (PREAMBLE_LEN <= 1) ? ST_SFD : ST_PREAMBLE;
            cnt_clear = 1'b1;
            cnt_inc   = 1'b1;
          end
        end
        ST_PREAMBLE: begin
          if (byte_in != PREAMBLE_BYTE) begin
            state_d   = ST_IDLE;
            err_d     = 1'b1;
            cnt_clear = 1'b1;
          end else if (cnt_last) begin
            state_d   = ST_SFD;
            cnt_clear = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_SFD: begin
          cnt_clear = 1'b1;
          if (byte_in == SFD_BYTE) begin
            state_d       = ST_DEST;
            bcast_d       = 1'b0;
            src_d         = '0;
            local_match_d = 1'b1;
            bcast_match_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
        ST_DEST: begin
          local_match_d = local_now;
          bcast_match_d = bcast_now;
          if (cnt_last) begin
            cnt_clear = 1'b1;
            if (local_now || bcast_now) begin
              state_d = ST_SRC;
              bcast_d = bcast_now;
            end else begin
              state_d = ST_IDLE;
              drop_d  = 1'b1;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_SRC: begin
          src_d = (src_addr << 8) | AW'(byte_in);
          if (cnt_last) begin
            // Rising here aligns the enable with the first payload byte.
            state_d   = ST_PAYLOAD;
            pe_d      = 1'b1;
            cnt_clear = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (cnt_last) begin
            state_d   = ST_IDLE;
            pe_d      = 1'b0;
            done_d    = 1'b1;
            cnt_clear = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          pe_d      = 1'b0;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      payload_enable <= 1'b0;
      dst_broadcast  <= 1'b0;
      src_addr       <= '0;
      local_match    <= 1'b0;
      bcast_match    <= 1'b0;
      frame_done     <= 1'b0;
      frame_drop     <= 1'b0;
      header_error   <= 1'b0;
    end else begin
      state          <= state_d;
      payload_enable <= pe_d;
      dst_broadcast  <= bcast_d;
      src_addr       <= src_d;
      local_match    <= local_match_d;
      bcast_match    <= bcast_match_d;
      frame_done     <= done_d;
      frame_drop     <= drop_d;
      header_error   <= err_d;
    end
  end

endmodule

// File: tb/tb_frame_header_parser.sv
// Testbench for frame_header_parser: directed frames followed by random frames.
// Expected pulses are queued by the driver and consumed by a monitor process.
module tb_frame_header_parser;

  localparam logic [47:0] LOCAL  = 48'h0A0B0C0D0E0F;
  localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;
  localparam logic [7:0]  PRE    = 8'h55;
  localparam logic [7:0]  SFD    = 8'hD5;
  localparam int          EV_DONE = 0;
  localparam int          EV_DROP = 1;
  localparam int          EV_ERR  = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        payload_enable, dst_broadcast, frame_done, frame_drop, header_error;
  logic [47:0] src_addr;
  logic        exp_pe = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          kind;
    logic [47:0] src;
    logic        bcast;
  } ev_t;
  ev_t exq[$];

  always #5 clock = ~clock;

  frame_header_parser dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .byte_in        (byte_in),
    .byte_valid     (byte_valid),
    .payload_enable (payload_enable),
    .dst_broadcast  (dst_broadcast),
    .src_addr       (src_addr),
    .frame_done     (frame_done),
    .frame_drop     (frame_drop),
    .header_error   (header_error)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input int kind);
    ev_t e;
    if (exq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_pulse: kind %0d seen, none expected at %0t", kind, $time);
    end else begin
      e = exq.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == EV_DONE && e.kind == EV_DONE) begin
        chk("src_addr", src_addr, e.src);
        chk("dst_broadcast", dst_broadcast, e.bcast);
      end else if (kind == EV_DROP && e.kind == EV_DROP) begin
        chk("drop_broadcast", dst_broadcast, 0);
        chk("drop_src_addr", src_addr, 0);
      end
    end
  endtask

  // Monitor: payload_enable every cycle, pulses against the expected queue.
  initial begin
    forever begin
      @(negedge clock);
      chk("payload_enable", payload_enable, exp_pe);
      if (frame_done)   pop_check(EV_DONE);
      if (frame_drop)   pop_check(EV_DROP);
      if (header_error) pop_check(EV_ERR);
    end
  end

  task automatic drive(input logic [7:0] b, input logic v, input logic pe);
    @(posedge clock);
    #1;
    byte_in    = b;
    byte_valid = v;
    exp_pe     = pe;
  endtask

  task automatic idle(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(1, 0) == 0) begin
        drive(8'h00, 1'b0, 1'b0);
      end else begin
        b = 8'($urandom);
        if (b == PRE) b = 8'h00;
        drive(b, 1'b1, 1'b0);
      end
    end
  endtask

  task automatic check_all_zero();
    chk("rst_payload_enable", payload_enable, 0);
    chk("rst_dst_broadcast", dst_broadcast, 0);
    chk("rst_src_addr", src_addr, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_drop", frame_drop, 0);
    chk("rst_header_error", header_error, 0);
  endtask

  // Frame layout: bytes 0-6 preamble, 7 SFD, 8-13 dst, 14-19 src, 20-69 payload.
  // gap: index replaced by a byte_valid=0 cycle; rst_at: index during which reset fires.
  task automatic send_frame(input int pre_bad, input logic [7:0] pre_val,
                            input logic [7:0] sfd_val, input logic [47:0] dst,
                            input logic [47:0] src, input int gap, input int rst_at);
    logic [7:0] fb[70];
    int         t;
    int         kind;
    bit         acc;
    ev_t        e;
    for (int i = 0; i < 7; i++) fb[i] = PRE;
    if (pre_bad >= 0) fb[pre_bad] = pre_val;
    fb[7] = sfd_val;
    for (int k = 0; k < 6; k++) begin
      fb[8 + k]  = dst[47 - 8*k -: 8];
      fb[14 + k] = src[47 - 8*k -: 8];
    end
    for (int i = 20; i < 70; i++) fb[i] = 8'($urandom);

    acc = (pre_bad < 0) && (sfd_val == SFD) && ((dst == LOCAL) || (dst == BCAST));
    if (pre_bad >= 0)        begin t = pre_bad; kind = EV_ERR;  end
    else if (sfd_val != SFD) begin t = 7;       kind = EV_ERR;  end
    else if (!acc)           begin t = 13;      kind = EV_DROP; end
    else                     begin t = 69;      kind = EV_DONE; end
    e.src   = src;
    e.bcast = (dst == BCAST);
    e.kind  = kind;

    for (int i = 0; i <= t; i++) begin
      if (i == gap) begin
        drive(8'h00, 1'b0, acc && i >= 20);
        e.kind = EV_ERR;
        exq.push_back(e);
        return;
      end
      drive(fb[i], 1'b1, acc && i >= 20);
      if (i == rst_at) begin
        #2;
        reset_n    = 1'b0;
        byte_valid = 1'b0;
        exp_pe     = 1'b0;
        #1;
        check_all_zero();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        #1;
        check_all_zero();
        reset_n = 1'b1;
        return;
      end
      if (i == t) exq.push_back(e);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    logic [47:0] dst, src;
    logic [7:0]  v;
    int          mode, k;

    repeat (3) @(posedge clock);
    #1;
    check_all_zero();
    reset_n = 1'b1;
    idle(3);

    // Local frame, then broadcast frame.
    send_frame(-1, 8'h00, SFD, LOCAL, 48'h112233445566, -1, -1);
    idle(2);
    send_frame(-1, 8'h00, SFD, BCAST, 48'h112233445566, -1, -1);
    idle(2);
    // Destination mismatch in the last byte.
    send_frame(-1, 8'h00, SFD, 48'h0A0B0C0D0E00, 48'hA1A2A3A4A5A6, -1, -1);
    idle(2);
    // Bad preamble byte, then an extra preamble byte where the SFD belongs.
    send_frame(2, 8'h54, SFD, LOCAL, 48'h010203040506, -1, -1);
    idle(2);
    send_frame(-1, 8'h00, PRE, LOCAL, 48'h010203040506, -1, -1);
    idle(2);
    // Gap at payload byte 20, then a normal frame.
    send_frame(-1, 8'h00, SFD, LOCAL, 48'hCAFE00BEEF01, 40, -1);
    idle(1);
    send_frame(-1, 8'h00, SFD, LOCAL, 48'h0F0E0D0C0B0A, -1, -1);
    idle(2);
    // Reset at payload byte 10, then two back-to-back frames.
    send_frame(-1, 8'h00, SFD, LOCAL, 48'h999999999999, -1, 30);
    send_frame(-1, 8'h00, SFD, LOCAL, 48'h123456789ABC, -1, -1);
    send_frame(-1, 8'h00, SFD, BCAST, 48'hFEDCBA987654, -1, -1);
    idle(2);

    for (int n = 0; n < 60; n++) begin
      src  = {$urandom, $urandom};
      mode = $urandom_range(9, 0);
      dst  = ($urandom_range(1, 0) == 0) ? LOCAL : BCAST;
      if (mode == 2 || mode == 3) begin
        k = $urandom_range(5, 0);
        do v = 8'($urandom); while (v == LOCAL[47 - 8*k -: 8] || v == 8'hFF);
        dst[47 - 8*k -: 8] = (mode == 3 && dst == LOCAL) ? 8'hFF : v;
      end
      if (mode == 0) begin
        do v = 8'($urandom); while (v == PRE);
        send_frame($urandom_range(6, 1), v, SFD, dst, src, -1, -1);
      end else if (mode == 1) begin
        do v = 8'($urandom); while (v == SFD);
        send_frame(-1, 8'h00, v, dst, src, -1, -1);
      end else if (mode == 4) begin
        send_frame(-1, 8'h00, SFD, dst, src, $urandom_range(69, 1), -1);
      end else begin
        send_frame(-1, 8'h00, SFD, dst, src, -1, -1);
      end
      idle($urandom_range(3, 0));
    end

    idle(4);
    chk("queue_empty", exq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
